serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes WIDTH-bit operands DIGIT bits per clock through a chain of full-adder cells with a registered carry between digits. It accepts one operation at a time over a valid/ready input handshake and presents the result over a valid/ready output handshake. Result flags are carry-out/no-borrow and signed overflow. It is the area-lean successor to the single-bit combinational full adder: same cell, reused across cycles, generalised in width, digit size and mode.

---
 rtl/adder_pkg.sv | 26 ++
 rtl/full_adder_cell.sv | 33 +++
 rtl/serial_adder.sv | 177 +++++++++++++++++
 tb/tb_serial_adder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents:
//   state_t      - control FSM states (IDLE accepts, RUN steps digits, DONE presents)
//   digit_count  - number of DIGIT-wide steps needed to cover WIDTH bits
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of clock steps one operation takes in RUN.
    function automatic int digit_count(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter width for digit_count steps, never narrower than one bit.
    function automatic int count_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder made of two half adders.
// Latency: purely combinational.
// Backpressure: n/a.
//
// Ports:
//   a, b  - addend bits
//   ci    - carry in
//   s     - sum bit
//   co    - carry out (either half adder may generate it, never both)
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic half_sum;
    logic carry1;
    logic carry2;

    // First half adder: a + b.
    assign half_sum = a ^ b;
    assign carry1   = a & b;

    // Second half adder: partial sum + carry in.
    assign s      = half_sum ^ ci;
    assign carry2 = half_sum & ci;

    // The two half-adder carries are mutually exclusive, so OR is exact.
    assign co = carry1 | carry2;

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock.
// Latency: result valid WIDTH/DIGIT edges after accept; one op per WIDTH/DIGIT+2 cycles.
// Backpressure: holds DONE with stable outputs until out_ready; in_ready low outside IDLE.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid / in_ready - operand handshake (a, b, sub, cin sampled on accept only)
//   sub                 - 0: a + b + cin, 1: a - b - cin (cin acts as borrow)
//   out_valid/out_ready - result handshake
//   sum                 - result modulo 2^WIDTH
//   cout                - carry out of MSB; for subtraction 1 means no borrow
//   overflow            - signed overflow (carry into MSB xor carry out of MSB)
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = digit_count(WIDTH, DIGIT);
    localparam int CNT_W = count_width(N);

    // Reject illegal geometries at elaboration.
    if (WIDTH < 2) begin : g_bad_width
        $error("serial_adder: WIDTH must be at least 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_adder: DIGIT must be positive and divide WIDTH");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic               accept;
    logic               step;
    logic               last_digit;

    // ------------------------------------------------------------------
    // Digit datapath: DIGIT chained full-adder cells on the low operand bits
    // ------------------------------------------------------------------
    logic [DIGIT:0]     carry_chain;
    logic [DIGIT-1:0]   digit_sum;
    logic [WIDTH-1:0]   sum_shift;
    logic               msb_ci;
    logic               chain_co;

    assign carry_chain[0] = carry_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (op_a_q[i]),
            .b  (op_b_q[i]),
            .ci (carry_chain[i]),
            .s  (digit_sum[i]),
            .co (carry_chain[i+1])
        );
    end

    // On the last digit the top cell is the operand MSB, so its carry-in
    // and the chain carry-out give the signed overflow condition.
    assign msb_ci   = carry_chain[DIGIT-1];
    assign chain_co = carry_chain[DIGIT];

    // Result bits enter from the MSB side; after N steps the first digit
    // has walked down to bit 0.
    if (DIGIT == WIDTH) begin : g_sum_whole
        assign sum_shift = digit_sum;
    end else begin : g_sum_shift
        assign sum_shift = {digit_sum, sum_q[WIDTH-1:DIGIT]};
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign last_digit = (cnt_q == CNT_W'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_digit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, carry, counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1; a borrow-in removes the +1.
            op_a_q  <= a;
            op_b_q  <= sub ? ~b : b;
            carry_q <= cin ^ sub;
            cnt_q   <= '0;
        end else if (step) begin
            op_a_q  <= op_a_q >> DIGIT;
            op_b_q  <= op_b_q >> DIGIT;
            sum_q   <= sum_shift;
            carry_q <= chain_co;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_digit) begin
                cout_q <= chain_co;
                ovf_q  <= msb_ci ^ chain_co;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registers only
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: instance 0 is WIDTH=8/DIGIT=1, instance 1 is WIDTH=8/DIGIT=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       rst       [2];
    logic       in_valid  [2];
    logic       out_ready [2];
    logic       sub_i     [2];
    logic       cin_i     [2];
    logic [7:0] a_i       [2];
    logic [7:0] b_i       [2];

    wire  [1:0] in_ready_w;
    wire  [1:0] out_valid_w;
    wire  [1:0] cout_w;
    wire  [1:0] ovf_w;
    wire  [7:0] sum_w     [2];

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
        .a(a_i[0]), .b(b_i[0]), .sub(sub_i[0]), .cin(cin_i[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready[0]),
        .sum(sum_w[0]), .cout(cout_w[0]), .overflow(ovf_w[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
        .a(a_i[1]), .b(b_i[1]), .sub(sub_i[1]), .cin(cin_i[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready[1]),
        .sum(sum_w[1]), .cout(cout_w[1]), .overflow(ovf_w[1])
    );

    // Reference: integer arithmetic on the unsigned and signed views of the operands.
    function automatic void ref_model(input logic [7:0] a, input logic [7:0] b,
                                      input logic s, input logic c,
                                      output logic [7:0] rs, output logic rc, output logic ro);
        int ua, ub, sa, sb, r, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!s) begin
            r  = ua + ub + int'(c);
            rc = (r > 255);
            sr = sa + sb + int'(c);
        end else begin
            r  = ua - ub - int'(c);
            rc = (ua >= ub + int'(c));
            sr = sa - sb - int'(c);
        end
        rs = r[7:0];
        ro = (sr > 127) || (sr < -128);
    endfunction

    function automatic int latency_of(input int idx);
        return (idx == 0) ? 8 : 2;
    endfunction

    // Issue one operation; returns edges from accept to out_valid (-1 on timeout).
    task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic c, output int lat,
                         output logic [7:0] rs, output logic rc, output logic ro);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready_w[idx] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a_i[idx] = a; b_i[idx] = b; sub_i[idx] = s; cin_i[idx] = c;
        in_valid[idx] = 1'b1;
        @(negedge clk);
        in_valid[idx] = 1'b0;
        a_i[idx] = 8'($urandom); b_i[idx] = 8'($urandom);
        sub_i[idx] = 1'($urandom); cin_i[idx] = 1'($urandom);
        lat = 0;
        while (!out_valid_w[idx] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50 || guard >= 50) lat = -1;
        rs = sum_w[idx]; rc = cout_w[idx]; ro = ovf_w[idx];
    endtask

    task automatic release_out(input int idx, output logic ov, output logic ir);
        out_ready[idx] = 1'b1;
        @(negedge clk);
        out_ready[idx] = 1'b0;
        ov = out_valid_w[idx];
        ir = in_ready_w[idx];
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; in_valid[i] = 1'b0; out_ready[i] = 1'b0;
            sub_i[i] = 1'b0; cin_i[i] = 1'b0; a_i[i] = '0; b_i[i] = '0;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({in_ready_w[i], out_valid_w[i], sum_w[i], cout_w[i], ovf_w[i]} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL reset_state[%0d]: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, expected rdy=1 vld=0 sum=00 cout=0 ovf=0",
                         i, in_ready_w[i], out_valid_w[i], sum_w[i], cout_w[i], ovf_w[i]);
            end
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (in_ready_w[i] !== 1'b1 || out_valid_w[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_release[%0d]: got rdy=%b vld=%b, expected rdy=1 vld=0", i, in_ready_w[i], out_valid_w[i]);
            end
        end
    endtask

    task automatic test_directed();
        // a, b, sub, cin, sum, cout, ovf, instance
        logic [7:0] ta [6] = '{8'h5A, 8'hFF, 8'hFF, 8'h10, 8'h80, 8'h7F};
        logic [7:0] tb [6] = '{8'h3C, 8'h01, 8'h01, 8'h20, 8'h01, 8'h01};
        logic       ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] es [6] = '{8'h96, 8'h00, 8'h01, 8'hF0, 8'h7F, 8'h80};
        logic       ec [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       eo [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int         ti [6] = '{0, 0, 0, 0, 0, 1};
        int lat;
        logic [7:0] rs;
        logic rc, ro, ov, ir;
        for (int k = 0; k < 6; k++) begin
            do_op(ti[k], ta[k], tb[k], ts[k], tc[k], lat, rs, rc, ro);
            checks++;
            if (lat != latency_of(ti[k])) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d edges, expected %0d", k, lat, latency_of(ti[k]));
            end
            checks++;
            if ({rs, rc, ro} !== {es[k], ec[k], eo[k]}) begin
                failures++;
                $display("FAIL directed_result[%0d]: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                         k, rs, rc, ro, es[k], ec[k], eo[k]);
            end
            release_out(ti[k], ov, ir);
            checks++;
            if (ov !== 1'b0 || ir !== 1'b1) begin
                failures++;
                $display("FAIL directed_release[%0d]: got vld=%b rdy=%b, expected vld=0 rdy=1", k, ov, ir);
            end
        end
    endtask

    task automatic test_random(input int idx, input int count);
        int lat;
        logic [7:0] a, b, rs, es;
        logic s, c, rc, ro, ec, eo, ov, ir;
        for (int k = 0; k < count; k++) begin
            a = 8'($urandom); b = 8'($urandom);
            s = 1'($urandom); c = 1'($urandom);
            ref_model(a, b, s, c, es, ec, eo);
            do_op(idx, a, b, s, c, lat, rs, rc, ro);
            checks++;
            if (lat != latency_of(idx) || {rs, rc, ro} !== {es, ec, eo}) begin
                failures++;
                $display("FAIL random[%0d.%0d] %h%s%h c=%b: got lat=%0d sum=%h cout=%b ovf=%b, expected lat=%0d sum=%h cout=%b ovf=%b",
                         idx, k, a, s ? "-" : "+", b, c, lat, rs, rc, ro, latency_of(idx), es, ec, eo);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_out(idx, ov, ir);
            checks++;
            if (ov !== 1'b0 || ir !== 1'b1) begin
                failures++;
                $display("FAIL random_release[%0d.%0d]: got vld=%b rdy=%b, expected vld=0 rdy=1", idx, k, ov, ir);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [7:0] a, b, rs, es;
        logic s, c, rc, ro, ec, eo, ov, ir;
        a = 8'($urandom); b = 8'($urandom); s = 1'($urandom); c = 1'($urandom);
        ref_model(a, b, s, c, es, ec, eo);
        do_op(0, a, b, s, c, lat, rs, rc, ro);
        for (int k = 0; k < 5; k++) begin
            in_valid[0] = k[0] ? 1'b0 : 1'b1;
            a_i[0] = 8'($urandom); b_i[0] = 8'($urandom);
            sub_i[0] = 1'($urandom); cin_i[0] = 1'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid_w[0] !== 1'b1 || in_ready_w[0] !== 1'b0 ||
                {sum_w[0], cout_w[0], ovf_w[0]} !== {es, ec, eo}) begin
                failures++;
                $display("FAIL backpressure[%0d]: got vld=%b rdy=%b sum=%h cout=%b ovf=%b, expected vld=1 rdy=0 sum=%h cout=%b ovf=%b",
                         k, out_valid_w[0], in_ready_w[0], sum_w[0], cout_w[0], ovf_w[0], es, ec, eo);
            end
        end
        in_valid[0] = 1'b0;
        release_out(0, ov, ir);
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release: got vld=%b rdy=%b, expected vld=0 rdy=1", ov, ir);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        logic [7:0] rs;
        logic rc, ro, ov, ir;
        @(negedge clk);
        a_i[0] = 8'h55; b_i[0] = 8'h22; sub_i[0] = 1'b0; cin_i[0] = 1'b0;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst[0] = 1'b1;
        #1;
        checks++;
        if (out_valid_w[0] !== 1'b0 || in_ready_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_run: got vld=%b rdy=%b, expected vld=0 rdy=1", out_valid_w[0], in_ready_w[0]);
        end
        @(negedge clk);
        rst[0] = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid_w[0] !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_abort: got out_valid high on %0d cycles, expected 0", seen);
        end
        do_op(0, 8'h01, 8'h01, 1'b0, 1'b0, lat, rs, rc, ro);
        checks++;
        if (lat != 8 || {rs, rc, ro} !== {8'h02, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_fresh_op: got lat=%0d sum=%h cout=%b ovf=%b, expected lat=8 sum=02 cout=0 ovf=0", lat, rs, rc, ro);
        end
        release_out(0, ov, ir);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [$];
        logic [7:0] got_s, es;
        logic       ec, eo;
        logic [9:0] exp_v;
        logic [9:0] res_q [$];
        int accepts, results, last_acc, cyc;
        accepts = 0; results = 0; last_acc = -1;
        exp_q.delete();
        res_q.delete();
        @(negedge clk);
        out_ready[1] = 1'b1;
        in_valid[1]  = 1'b1;
        for (cyc = 0; cyc < 80 && results < 8; cyc++) begin
            if (accepts >= 8) in_valid[1] = 1'b0;
            if (out_valid_w[1]) begin
                got_s = sum_w[1];
                checks++;
                if (res_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected: result sum=%h with nothing outstanding", got_s);
                end else begin
                    exp_v = res_q.pop_front();
                    if ({got_s, cout_w[1], ovf_w[1]} !== exp_v) begin
                        failures++;
                        $display("FAIL b2b_result[%0d]: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                                 results, got_s, cout_w[1], ovf_w[1], exp_v[9:2], exp_v[1], exp_v[0]);
                    end
                end
                results++;
            end
            if (in_ready_w[1] && in_valid[1]) begin
                a_i[1] = 8'($urandom); b_i[1] = 8'($urandom);
                sub_i[1] = 1'($urandom); cin_i[1] = 1'($urandom);
                ref_model(a_i[1], b_i[1], sub_i[1], cin_i[1], es, ec, eo);
                res_q.push_back({es, ec, eo});
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 4) begin
                        failures++;
                        $display("FAIL b2b_spacing[%0d]: got %0d cycles between accepts, expected 4", accepts, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                accepts++;
            end
            @(negedge clk);
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b0;
        checks++;
        if (accepts != 8 || results != 8) begin
            failures++;
            $display("FAIL b2b_count: got accepts=%0d results=%0d, expected 8 and 8", accepts, results);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(0, 20);
        test_random(1, 20);
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
